// File: rtl/lsu.sv
// Load/store unit: alignment check, byte-lane steering and a req/ack bus
// transaction with timeout, returning extended load data to writeback.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_load_op,
    input  logic [2:0]  req_store_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        resp_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t         state_q, state_d;
    size_t          size_q, size_d, in_size;
    logic           sgn_q, sgn_d, in_sgn, in_misalign;
    logic [1:0]     lane_q, lane_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     in_be;
    logic [31:0]    in_wdata, ext_data;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic           req_ready_d, resp_valid_d, resp_misalign_d, resp_err_d;
    logic           bus_req_d, bus_we_d;
    logic [31:0]    resp_rdata_d, bus_addr_d, bus_wdata_d;
    logic [3:0]     bus_be_d;

    // Request decode: size, signedness, alignment, enables and lane-replicated data
    always_comb begin
        in_size = SZ_W;
        in_sgn  = 1'b0;
        if (req_write) begin
            case (req_store_op)
                3'd0:    in_size = SZ_B;
                3'd1:    in_size = SZ_H;
                default: in_size = SZ_W;
            endcase
        end else begin
            case (req_load_op)
                3'd0:    begin in_size = SZ_B; in_sgn = 1'b1; end
                3'd1:    begin in_size = SZ_H; in_sgn = 1'b1; end
                3'd4:    in_size = SZ_B;
                3'd5:    in_size = SZ_H;
                default: in_size = SZ_W;
            endcase
        end
        in_misalign = ((in_size == SZ_H) && req_addr[0]) ||
                      ((in_size == SZ_W) && (req_addr[1:0] != 2'b00));
        case (in_size)
            SZ_B: begin
                in_be    = 4'b0001 << req_addr[1:0];
                in_wdata = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                in_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                in_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                in_be    = 4'b1111;
                in_wdata = req_wdata;
            end
        endcase
    end

    // Load extraction from the returned word
    always_comb begin
        byte_sel = bus_rdata[{lane_q, 3'b000} +: 8];
        half_sel = bus_rdata[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_B:    ext_data = sgn_q ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
            SZ_H:    ext_data = sgn_q ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
            default: ext_data = bus_rdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d         = state_q;
        size_d          = size_q;
        sgn_d           = sgn_q;
        lane_d          = lane_q;
        cnt_d           = cnt_q;
        bus_req_d       = bus_req;
        bus_we_d        = bus_we;
        bus_addr_d      = bus_addr;
        bus_be_d        = bus_be;
        bus_wdata_d     = bus_wdata;
        resp_valid_d    = 1'b0;
        resp_misalign_d = 1'b0;
        resp_err_d      = 1'b0;
        resp_rdata_d    = 32'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    size_d = in_size;
                    sgn_d  = in_sgn;
                    lane_d = req_addr[1:0];
                    if (in_misalign) begin
                        state_d         = RESP;
                        resp_valid_d    = 1'b1;
                        resp_misalign_d = 1'b1;
                    end else begin
                        state_d     = BUS;
                        cnt_d       = CW'(0);
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_write;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_be_d    = in_be;
                        bus_wdata_d = in_wdata;
                    end
                end
            end
            BUS: begin
                if (bus_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = !bus_ack;
                    resp_rdata_d = (bus_ack && !bus_we) ? ext_data : 32'b0;
                    bus_req_d    = 1'b0;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = 32'b0;
                    bus_be_d     = 4'b0;
                    bus_wdata_d  = 32'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            size_q        <= SZ_W;
            sgn_q         <= 1'b0;
            lane_q        <= 2'b0;
            cnt_q         <= CW'(0);
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_misalign <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= 32'b0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= 32'b0;
            bus_be        <= 4'b0;
            bus_wdata     <= 32'b0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            sgn_q         <= sgn_d;
            lane_q        <= lane_d;
            cnt_q         <= cnt_d;
            req_ready     <= req_ready_d;
            resp_valid    <= resp_valid_d;
            resp_misalign <= resp_misalign_d;
            resp_err      <= resp_err_d;
            resp_rdata    <= resp_rdata_d;
            bus_req       <= bus_req_d;
            bus_we        <= bus_we_d;
            bus_addr      <= bus_addr_d;
            bus_be        <= bus_be_d;
            bus_wdata     <= bus_wdata_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table of single accesses plus sequences for
// stalls, timeout, back-to-back throughput and mid-transaction reset.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, bus_ack, l_req_valid, l_bus_ack;
    logic [2:0]  req_load_op, req_store_op;
    logic [31:0] req_addr, req_wdata, bus_rdata;
    logic        req_ready, resp_valid, resp_misalign, resp_err, bus_req, bus_we;
    logic [31:0] resp_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        l_req_ready, l_resp_valid, l_resp_misalign, l_resp_err, l_bus_req, l_bus_we;
    logic [31:0] l_resp_rdata, l_bus_addr, l_bus_wdata;
    logic [3:0]  l_bus_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_load_op(req_load_op), .req_store_op(req_store_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_misalign(resp_misalign), .resp_err(resp_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    // Default-timeout instance used for the long stall sequence
    lsu dut_long (
        .clk(clk), .rst_n(rst_n), .req_valid(l_req_valid), .req_ready(l_req_ready),
        .req_write(req_write), .req_load_op(req_load_op), .req_store_op(req_store_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(l_resp_valid),
        .resp_rdata(l_resp_rdata), .resp_misalign(l_resp_misalign), .resp_err(l_resp_err),
        .bus_req(l_bus_req), .bus_we(l_bus_we), .bus_addr(l_bus_addr), .bus_be(l_bus_be),
        .bus_wdata(l_bus_wdata), .bus_ack(l_bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  lop;
        logic [2:0]  sop;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] erdata;
    } vec_t;

    vec_t vec [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic wr, input logic [2:0] lop, input logic [2:0] sop,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_write    = wr;
        req_load_op  = lop;
        req_store_op = sop;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    int n;
    int nacc;
    int nresp;
    int acc_cyc [3];
    logic acc_now;
    logic saw_resp;

    initial begin
        vec[0]  = '{1'b0, 3'd0, 3'd0, 32'h1003, 32'h0, 32'h80FF_FF7F, 1'b0, 4'b1000, 32'h1000, 32'h0, 32'hFFFF_FF80};
        vec[1]  = '{1'b0, 3'd4, 3'd0, 32'h1003, 32'h0, 32'h80FF_FF7F, 1'b0, 4'b1000, 32'h1000, 32'h0, 32'h0000_0080};
        vec[2]  = '{1'b0, 3'd2, 3'd0, 32'h3001, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0, 32'h0};
        vec[3]  = '{1'b0, 3'd1, 3'd0, 32'h3001, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0, 32'h0};
        vec[4]  = '{1'b0, 3'd0, 3'd0, 32'h3001, 32'h0, 32'h80FF_FF7F, 1'b0, 4'b0010, 32'h3000, 32'h0, 32'hFFFF_FFFF};
        vec[5]  = '{1'b0, 3'd5, 3'd0, 32'h4002, 32'h0, 32'h8001_1234, 1'b0, 4'b1100, 32'h4000, 32'h0, 32'h0000_8001};
        vec[6]  = '{1'b0, 3'd1, 3'd0, 32'h4000, 32'h0, 32'h1234_9ABC, 1'b0, 4'b0011, 32'h4000, 32'h0, 32'hFFFF_9ABC};
        vec[7]  = '{1'b0, 3'd2, 3'd0, 32'h5004, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h5004, 32'h0, 32'hDEAD_BEEF};
        vec[8]  = '{1'b0, 3'd7, 3'd0, 32'h5002, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0, 32'h0};
        vec[9]  = '{1'b0, 3'd3, 3'd0, 32'h6000, 32'h0, 32'h0123_4567, 1'b0, 4'b1111, 32'h6000, 32'h0, 32'h0123_4567};
        vec[10] = '{1'b1, 3'd0, 3'd0, 32'h7001, 32'h1234_56A5, 32'hFFFF_FFFF, 1'b0, 4'b0010, 32'h7000, 32'hA5A5_A5A5, 32'h0};
        vec[11] = '{1'b1, 3'd0, 3'd2, 32'h7008, 32'hCAFE_F00D, 32'h1234_5678, 1'b0, 4'b1111, 32'h7008, 32'hCAFE_F00D, 32'h0};
        vec[12] = '{1'b1, 3'd0, 3'd5, 32'h7002, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0, 32'h0};
        vec[13] = '{1'b1, 3'd0, 3'd1, 32'h7001, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0, 32'h0, 32'h0};
        vec[14] = '{1'b1, 3'd0, 3'd1, 32'h2002, 32'h1234_ABCD, 32'h5555_5555, 1'b0, 4'b1100, 32'h2000, 32'hABCD_ABCD, 32'h0};

        rst_n = 1'b0;
        req_valid = 1'b0; l_req_valid = 1'b0; bus_ack = 1'b0; l_bus_ack = 1'b0;
        bus_rdata = 32'h0;
        set_req(1'b0, 3'd0, 3'd0, 32'h0, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Reset/idle state
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_misalign", 32'(resp_misalign), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);

        // Single accesses with zero-wait ack
        for (int i = 0; i < 15; i++) begin
            set_req(vec[i].wr, vec[i].lop, vec[i].sop, vec[i].addr, vec[i].wdata);
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            if (vec[i].mis) begin
                chk($sformatf("v%0d_no_bus_req", i), 32'(bus_req), 32'd0);
                chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'd1);
                chk($sformatf("v%0d_misalign", i), 32'(resp_misalign), 32'd1);
                chk($sformatf("v%0d_err", i), 32'(resp_err), 32'd0);
                chk($sformatf("v%0d_rdata", i), resp_rdata, 32'h0);
            end else begin
                chk($sformatf("v%0d_bus_req", i), 32'(bus_req), 32'd1);
                chk($sformatf("v%0d_bus_we", i), 32'(bus_we), 32'(vec[i].wr));
                chk($sformatf("v%0d_bus_addr", i), bus_addr, vec[i].baddr);
                chk($sformatf("v%0d_bus_be", i), 32'(bus_be), 32'(vec[i].be));
                if (vec[i].wr)
                    chk($sformatf("v%0d_bus_wdata", i), bus_wdata, vec[i].bwdata);
                chk($sformatf("v%0d_early_resp", i), 32'(resp_valid), 32'd0);
                bus_ack = 1'b1;
                bus_rdata = vec[i].rdata;
                step();
                bus_ack = 1'b0;
                chk($sformatf("v%0d_bus_req_drop", i), 32'(bus_req), 32'd0);
                chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'd1);
                chk($sformatf("v%0d_misalign", i), 32'(resp_misalign), 32'd0);
                chk($sformatf("v%0d_err", i), 32'(resp_err), 32'd0);
                chk($sformatf("v%0d_rdata", i), resp_rdata, vec[i].erdata);
            end
            step();
            chk($sformatf("v%0d_pulse_end", i), 32'(resp_valid), 32'd0);
            chk($sformatf("v%0d_flags_clr", i), 32'(resp_misalign), 32'd0);
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
        end

        // Store half with a 5-cycle ack stall on the long-timeout instance
        set_req(1'b1, 3'd0, 3'd1, 32'h2002, 32'h1234_ABCD);
        l_req_valid = 1'b1;
        step();
        l_req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_req", c), 32'(l_bus_req), 32'd1);
            chk($sformatf("stall%0d_we", c), 32'(l_bus_we), 32'd1);
            chk($sformatf("stall%0d_addr", c), l_bus_addr, 32'h2000);
            chk($sformatf("stall%0d_be", c), 32'(l_bus_be), 32'b1100);
            chk($sformatf("stall%0d_wdata", c), l_bus_wdata, 32'hABCD_ABCD);
            chk($sformatf("stall%0d_resp", c), 32'(l_resp_valid), 32'd0);
            step();
        end
        chk("stall_req_held", 32'(l_bus_req), 32'd1);
        l_bus_ack = 1'b1;
        bus_rdata = 32'h7777_7777;
        step();
        l_bus_ack = 1'b0;
        chk("stall_resp_valid", 32'(l_resp_valid), 32'd1);
        chk("stall_rdata", l_resp_rdata, 32'h0);
        chk("stall_err", 32'(l_resp_err), 32'd0);
        chk("stall_misalign", 32'(l_resp_misalign), 32'd0);
        step();
        chk("stall_pulse_end", 32'(l_resp_valid), 32'd0);
        chk("stall_ready", 32'(l_req_ready), 32'd1);

        // Timeout with no ack: bus_req high exactly 4 cycles
        set_req(1'b0, 3'd2, 3'd0, 32'h8000, 32'h0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n = 0;
        while (bus_req && n < 20) begin
            n++;
            step();
        end
        chk("to_req_cycles", 32'(n), 32'd4);
        chk("to_resp_valid", 32'(resp_valid), 32'd1);
        chk("to_err", 32'(resp_err), 32'd1);
        chk("to_rdata", resp_rdata, 32'h0);
        step();
        chk("to_err_clr", 32'(resp_err), 32'd0);

        // Ack in the 4th cycle wins over the timeout
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("late%0d_req", c), 32'(bus_req), 32'd1);
            step();
        end
        chk("late_req4", 32'(bus_req), 32'd1);
        bus_ack = 1'b1;
        bus_rdata = 32'h1122_3344;
        step();
        bus_ack = 1'b0;
        chk("late_resp_valid", 32'(resp_valid), 32'd1);
        chk("late_err", 32'(resp_err), 32'd0);
        chk("late_rdata", resp_rdata, 32'h1122_3344);
        step();

        // Back-to-back word loads with req_valid held and bus_ack stuck high
        set_req(1'b0, 3'd2, 3'd0, 32'h9000, 32'h0);
        req_valid = 1'b1;
        bus_ack = 1'b1;
        nacc = 0;
        nresp = 0;
        for (int c = 0; c < 16; c++) begin
            bus_rdata = 32'h0BAD_0000 | 32'(nresp);
            acc_now = req_valid && req_ready;
            step();
            if (acc_now) begin
                if (nacc < 3) acc_cyc[nacc] = c;
                nacc++;
                if (nacc == 3) req_valid = 1'b0;
                else req_addr = req_addr + 32'd4;
            end
            if (resp_valid) begin
                chk($sformatf("b2b_rdata%0d", nresp), resp_rdata, 32'h0BAD_0000 | 32'(nresp));
                nresp++;
            end
        end
        bus_ack = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd3);
        chk("b2b_resps", 32'(nresp), 32'd3);
        if (nacc == 3) begin
            chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end

        // Asynchronous reset during a bus transaction
        set_req(1'b0, 3'd2, 3'd0, 32'hA000, 32'h0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("arst_req_before", 32'(bus_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_drop", 32'(bus_req), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        step();
        #3;
        rst_n = 1'b1;
        bus_ack = 1'b1;
        saw_resp = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (resp_valid || bus_req) saw_resp = 1'b1;
        end
        bus_ack = 1'b0;
        chk("arst_no_resp", 32'(saw_resp), 32'd0);
        chk("arst_idle_ready", 32'(req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit on the far side of the decoder's memory-control outputs (memvalid, memwrite, load_op, store_op).
- Takes one memory request per handshake from the execute stage: effective address, store data and access size.
- Performs alignment checking, byte-lane steering and byte enables, then runs a request/ack transaction on the data bus.
- Returns sign/zero-extended load data, or a misalign/timeout error, to writeback.

Parameters:
- TIMEOUT, 255, max cycles bus_req stays high without bus_ack before the access is aborted with an error (1..255).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present (the decoder's memvalid, qualified by pipeline)
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1=store, 0=load (the decoder's memwrite)
- req_load_op  in  3  params.vh encoding: BYTE_S=0, HALF_S=1, WORD=2, BYTE_U=4, HALF_U=5
- req_store_op  in  3  params.vh encoding: BYTE=0, HALF=1, WORD=2
- req_addr  in  32  byte effective address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_misalign  out  1  address misaligned for size, qualified by resp_valid
- resp_err  out  1  bus timeout, qualified by resp_valid
- bus_req  out  1  bus request, held until ack or timeout
- bus_we  out  1  bus write
- bus_addr  out  32  word address {req_addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completes access this cycle; bus_rdata valid in the same cycle
- bus_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - req_ready=1 once released.
  - resp_valid, resp_misalign, resp_err, bus_req, bus_we = 0.
  - bus_addr, bus_be, bus_wdata, resp_rdata = 0.
- Reset mid-transaction: bus_req drops immediately and the pending response is discarded.
- FSM IDLE / BUS / RESP:
  - req_ready = (state==IDLE).
  - Accept when req_valid & req_ready; request fields are registered at acceptance.
- Size decode:
  - Undefined load_op (3,6,7) is treated as WORD.
  - Undefined store_op (3..7) is treated as WORD.
- Misalignment:
  - HALF with addr[0]=1 is misaligned.
  - WORD with addr[1:0]!=0 is misaligned.
  - On misalign: IDLE->RESP, no bus cycle, resp_misalign=1, resp_rdata=0.
  - Latency 1 cycle after acceptance.
- Aligned request: IDLE->BUS. bus_req, bus_we, bus_addr, bus_be, bus_wdata are registered and valid from the cycle after acceptance and held stable until exit.
- Byte enables:
  - BYTE: be = 4'b0001<<addr[1:0].
  - HALF: be = addr[1] ? 4'b1100 : 4'b0011.
  - WORD: be = 4'b1111.
  - Loads and stores use the same enables.
- Store data:
  - BYTE: {4{wdata[7:0]}}.
  - HALF: {2{wdata[15:0]}}.
  - WORD: wdata.
- BUS state:
  - A per-transaction counter starts at 0 on entry and increments each BUS cycle without ack.
  - On bus_ack: latch the extracted read data, go to RESP, bus_req=0 next cycle.
  - If counter==TIMEOUT-1 and no ack: go to RESP with resp_err=1, resp_rdata=0.
  - Ack in the same cycle as the timeout: ack wins, err=0.
- bus_ack outside BUS is ignored.
- Load extraction (lane = addr[1:0]):
  - BYTE_S / BYTE_U: sign/zero-extend bus_rdata[8*lane+:8].
  - HALF_S / HALF_U: sign/zero-extend bus_rdata[16*addr[1]+:16].
  - WORD: bus_rdata unchanged.
- Stores: resp_rdata=0.
- RESP state:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - resp_misalign and resp_err are 0 whenever resp_valid=0.
- Throughput:
  - Zero-wait ack gives accept at T, bus_req at T+1, resp_valid at T+2, req_ready again at T+3.
  - Back-to-back requests are spaced 3 cycles minimum.

Test Plan:
- Reset then idle:
  - req_ready=1, all other outputs 0.
  - Assert rst_n=0 while bus_req=1 -> bus_req falls with no clock edge, and no resp_valid follows.
- Load byte signed, addr=0x1003, bus_rdata=0x80FF_FF7F, ack on first BUS cycle:
  - bus_addr=0x1000, be=4'b1000.
  - resp_rdata=0xFFFF_FF80 two cycles after accept.
  - Same with BYTE_U -> 0x0000_0080.
- Store half, addr=0x2002, wdata=0x1234_ABCD:
  - bus_we=1, be=4'b1100, bus_wdata=0xABCD_ABCD.
  - Hold bus_ack low 5 cycles: outputs stable, resp_valid one cycle after ack, resp_rdata=0.
- Misaligned word load, addr=0x3001:
  - No bus_req.
  - resp_valid with resp_misalign=1 one cycle after accept.
  - HALF at 0x3001 also misaligned; BYTE at 0x3001 is not.
- Timeout, TIMEOUT=4, ack never asserted:
  - bus_req high exactly 4 cycles.
  - Then resp_valid with resp_err=1, resp_rdata=0.
  - Repeat with ack in the 4th cycle -> resp_err=0, data returned.
- req_valid held continuously with 3 word loads and zero-wait ack:
  - Accepts spaced 3 cycles apart.
  - Exactly three resp_valid pulses.
  - Stray bus_ack pulses in IDLE have no effect.
